// File: rtl/mux_arb_nw_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mux_arb_nw_if : request/response bundle for the N-channel arbiter mux     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface mux_arb_nw_if #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4
);
    localparam int CW = (NCH > 2) ? $clog2(NCH) : 1;

    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [CW-1:0]        out_ch;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/mux_arb_nw.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mux_arb_nw : NCH-way fixed-priority / round-robin registered selector    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mux_arb_nw #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mode,
    mux_arb_nw_if.slave bus
);
    localparam int CW = (NCH > 2) ? $clog2(NCH) : 1;

    logic [WIDTH-1:0]   r_data;
    logic [CW-1:0]      r_ch;
    logic               r_valid;
    logic [CW-1:0]      r_last;

    logic               w_load;
    logic               w_any;
    logic               w_xfer;
    logic [CW:0]        w_start;
    logic [2*NCH-1:0]   w_dbl;
    logic [NCH-1:0]     w_rot;
    logic [CW-1:0]      w_fix_idx;
    logic [CW-1:0]      w_rot_idx;
    logic [CW:0]        w_sum;
    logic [CW-1:0]      w_grant;
    logic [WIDTH-1:0]   w_sel_data;
    logic [NCH-1:0]     w_ready;

    assign w_load = !r_valid || bus.out_ready;
    assign w_any  = |bus.in_valid;
    // Gated by rst_n so nothing is accepted while reset is asserted.
    assign w_xfer = w_load && w_any && rst_n;

    // Round-robin: rotate requests so the channel after r_last sits at bit 0,
    // pick the lowest set bit, then rotate the index back.
    always_comb begin
        w_start = (r_last == CW'(NCH - 1)) ? '0 : ({1'b0, r_last} + 1'b1);
        w_dbl   = {bus.in_valid, bus.in_valid} >> w_start;
        w_rot   = w_dbl[NCH-1:0];

        w_fix_idx = '0;
        w_rot_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (bus.in_valid[i]) w_fix_idx = CW'(i);
            if (w_rot[i])        w_rot_idx = CW'(i);
        end

        w_sum = {1'b0, w_rot_idx} + w_start;
        if (w_sum >= (CW + 1)'(NCH)) w_sum = w_sum - (CW + 1)'(NCH);

        w_grant = mode ? w_sum[CW-1:0] : w_fix_idx;
    end

    always_comb begin
        w_sel_data = '0;
        w_ready    = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_grant == CW'(i)) begin
                w_sel_data = bus.in_data[i*WIDTH +: WIDTH];
                w_ready[i] = w_xfer;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ch    <= '0;
            r_last  <= CW'(NCH - 1);
        end else if (w_load) begin
            if (w_any) begin
                r_valid <= 1'b1;
                r_data  <= w_sel_data;
                r_ch    <= w_grant;
                if (mode) r_last <= w_grant;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_data  = r_data;
    assign bus.out_ch    = r_ch;
    assign bus.out_valid = r_valid;

endmodule
`default_nettype wire

// File: doc/mux_arb_nw.md
Name: mux_arb_nw

Overview:
- Parametrised N-channel, W-bit registered selector with valid/ready handshakes; successor to the fixed 16-bit 2:1 datapath mux.
- Arbitrates among NCH requesting sources in fixed-priority or round-robin mode.
- Forwards the winner's word through one output register stage, tagged with the source channel index.
- Used in the processor datapath where several producers (ALU, load unit, immediate path, forwarding path) share one writeback/operand bus.

Parameters:
- WIDTH, 16, data width per channel in bits (>=1).
- NCH, 4, number of input channels (>=2).
- CW, derived = max(1, clog2(NCH)), width of the channel-index output; not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel request/valid.
- in_ready  output  NCH  per-channel accept; at most one bit high.
- mode  input  1  0 = fixed priority (lowest index wins), 1 = round-robin.
- out_data  output  WIDTH  registered selected word.
- out_ch  output  CW  registered index of the channel that supplied out_data.
- out_valid  output  1  registered; out_data/out_ch are valid.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (rst_n low, asynchronous assert): out_valid=0, out_data=0, out_ch=0, RR pointer last=NCH-1. Deassertion is taken synchronously by the surrounding reset logic.
- load = !out_valid | out_ready (combinational). The output register may take a new word this cycle.
- Grant g is combinational from in_valid, mode and last:
  - Fixed: lowest index i with in_valid[i]=1.
  - Round-robin: first i with in_valid[i]=1, searching last+1, last+2, ... modulo NCH.
  - No request: no grant.
- in_ready[g] = load & any(in_valid); all other in_ready bits are 0. in_ready never depends on in_data.
- Input transfer on channel g occurs when in_valid[g] & in_ready[g].
- On transfer at a clock edge: out_data<=in_data[g], out_ch<=g, out_valid<=1. In RR mode, last<=g.
- Output transfer occurs when out_valid & out_ready.
- If load and no request: out_valid<=0; out_data and out_ch hold their values.
- Stall (out_valid & !out_ready): out_data, out_ch and out_valid hold; all in_ready=0.
- Latency: 1 cycle input transfer to out_valid.
- Throughput: one word per cycle while out_ready=1.
- Simultaneous output drain and new input transfer in the same cycle are permitted (back-to-back, no bubble).
- RR pointer:
  - Updates only on an input transfer in mode=1.
  - In mode=0 it holds.
  - A mode change takes effect at the next grant evaluation; no flush, pointer retained.
- Wrap-around: with last=NCH-1 the search starts at channel 0.
- A single requester is granted every cycle it requests, in either mode.
- Sources must hold in_valid/in_data until ready. A source dropping in_valid without transfer is not an error; the grant is re-evaluated each cycle.
- Reset mid-operation: a pending output word is discarded (out_valid=0 immediately); no word is transferred on the reset cycle.
- in_ready is combinational from out_ready. Downstream must not derive out_ready from in_ready (no loop).
- Unused high encodings of out_ch (NCH not a power of 2) never appear.

Test Plan:
- Reset with all in_valid=1, out_ready=1 → out_valid=0, out_data=0, out_ch=0, in_ready=0000 while rst_n=0. First cycle after release: mode=1 grants ch0 (in_ready=0001); out_ch=0 next cycle.
- mode=0, in_valid=1111, out_ready=1, data ch0..3=0x1111/0x2222/0x3333/0x4444 for 4 cycles → out_data=0x1111, out_ch=0 every cycle; channels 1-3 never readied.
- mode=1, in_valid=1111 held, out_ready=1 → out_ch sequence 0,1,2,3,0,1 on consecutive cycles, no bubbles; out_data follows the matching words.
- mode=1, in_valid=1010 → grants alternate 1,3,1,3. Then drop ch3 → ch1 granted every cycle.
- Backpressure: word 0xBEEF from ch2 in register, out_ready=0 for 3 cycles with in_valid=0100 → out_data=0xBEEF, out_ch=2 stable; in_ready=0000. Raise out_ready → 0xBEEF drains, next ch2 word loads the same edge.
- WIDTH=8, NCH=3 instance, mode=1, last=2, in_valid=111 → grant 0 (wrap); out_ch never 3. Assert rst_n=0 mid-stall → out_valid drops immediately.
